// File: rtl/ser_word_rx_if.sv
// Serial bit stream in, parallel word out with valid/ready and error pulses.
// master drives the serial line and consumes words; slave is the receiver.
interface ser_word_rx_if #(
    parameter int unsigned WIDTH = 4
);
    logic             sdi;
    logic             sen;
    logic [WIDTH-1:0] dout;
    logic             dvalid;
    logic             dready;
    logic             busy;
    logic             perr;
    logic             ferr;
    logic             ovr;

    modport master (
        output sdi, sen, dready,
        input  dout, dvalid, busy, perr, ferr, ovr
    );

    modport slave (
        input  sdi, sen, dready,
        output dout, dvalid, busy, perr, ferr, ovr
    );
endinterface

// File: rtl/ser_word_rx.sv
// Start/data/parity/stop frame receiver feeding a one-entry valid/ready word buffer.
// Error pulses (perr, ferr, ovr) last one cycle and are raised on the stop-bit strobe.
module ser_word_rx #(
    parameter int unsigned WIDTH = 4
) (
    input logic          clk,
    input logic          rst,
    ser_word_rx_if.slave bus
);
    localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             par_bad_q, par_bad_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dvalid_q, dvalid_d;
    logic             perr_q, perr_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;
    logic             buf_free;
    logic             last_bit;

    // A word being drained this cycle frees the slot for a same-edge commit.
    assign buf_free = !dvalid_q || bus.dready;
    assign last_bit = (cnt_q == CntW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.sen) begin
            unique case (state_q)
                StIdle:   if (!bus.sdi) state_d = StData;
                StData:   if (last_bit) state_d = StParity;
                StParity: state_d = StStop;
                StStop:   state_d = StIdle;
                default:  state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        par_bad_d = par_bad_q;
        dout_d    = dout_q;
        dvalid_d  = dvalid_q && !bus.dready;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
        ovr_d     = 1'b0;
        if (bus.sen) begin
            unique case (state_q)
                StIdle: begin
                    if (!bus.sdi) cnt_d = '0;
                end
                StData: begin
                    shreg_d = {shreg_q[WIDTH-2:0], bus.sdi};
                    cnt_d   = cnt_q + 1'b1;
                end
                StParity: begin
                    par_bad_d = (^shreg_q) ^ bus.sdi;
                end
                StStop: begin
                    if (!bus.sdi) begin
                        ferr_d = 1'b1;
                    end else if (par_bad_q) begin
                        perr_d = 1'b1;
                    end else if (buf_free) begin
                        dout_d   = shreg_q;
                        dvalid_d = 1'b1;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q   <= '0;
            cnt_q     <= '0;
            par_bad_q <= 1'b0;
            dout_q    <= '0;
            dvalid_q  <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            par_bad_q <= par_bad_d;
            dout_q    <= dout_d;
            dvalid_q  <= dvalid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    assign bus.dout   = dout_q;
    assign bus.dvalid = dvalid_q;
    assign bus.busy   = (state_q != StIdle);
    assign bus.perr   = perr_q;
    assign bus.ferr   = ferr_q;
    assign bus.ovr    = ovr_q;
endmodule

// File: tb/tb_ser_word_rx.sv
// Directed bench for ser_word_rx (WIDTH=4): good, sparse, parity, framing, overrun, reset.
module tb_ser_word_rx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    ser_word_rx_if #(.WIDTH(4)) bus ();

    ser_word_rx #(.WIDTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // gap idle cycles (sen=0, random sdi), then one strobe carrying b.
    task automatic send_bit(input logic b, input int gap, input bit chk_busy);
        for (int i = 0; i < gap; i++) begin
            bus.sen = 1'b0;
            bus.sdi = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            if (chk_busy) check("busy_gap", 16'(bus.busy), 16'd1);
        end
        bus.sen = 1'b1;
        bus.sdi = b;
        @(posedge clk);
        #1;
        bus.sen = 1'b0;
        bus.sdi = 1'b1;
    endtask

    task automatic frame(input logic [3:0] data, input logic par, input logic stop,
                         input int gap, input bit rdy_on_stop);
        send_bit(1'b0, 0, 1'b0);
        for (int i = 3; i >= 0; i--) send_bit(data[i], gap, gap > 0);
        send_bit(par, gap, gap > 0);
        if (rdy_on_stop) bus.dready = 1'b1;
        send_bit(stop, gap, gap > 0);
        bus.dready = 1'b0;
    endtask

    task automatic drain();
        bus.dready = 1'b1;
        @(posedge clk);
        #1;
        bus.dready = 1'b0;
        check("drain_dvalid", 16'(bus.dvalid), 16'd0);
    endtask

    task automatic check_pulses(input string tag, input logic p, input logic f, input logic o);
        check({tag, "_perr"}, 16'(bus.perr), 16'(p));
        check({tag, "_ferr"}, 16'(bus.ferr), 16'(f));
        check({tag, "_ovr"}, 16'(bus.ovr), 16'(o));
    endtask

    initial begin
        bus.sdi    = 1'b1;
        bus.sen    = 1'b0;
        bus.dready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_dout", 16'(bus.dout), 16'h0);
        check("rst_dvalid", 16'(bus.dvalid), 16'd0);
        check("rst_busy", 16'(bus.busy), 16'd0);
        check_pulses("rst", 1'b0, 1'b0, 1'b0);

        // Good frame, continuous strobes.
        frame(4'b1011, 1'b1, 1'b1, 0, 1'b0);
        check("good_dout", 16'(bus.dout), 16'hb);
        check("good_dvalid", 16'(bus.dvalid), 16'd1);
        check("good_busy", 16'(bus.busy), 16'd0);
        check_pulses("good", 1'b0, 1'b0, 1'b0);
        drain();

        // Sparse strobes: busy checked in every gap cycle.
        frame(4'b1011, 1'b1, 1'b1, 2, 1'b0);
        check("sparse_dout", 16'(bus.dout), 16'hb);
        check("sparse_dvalid", 16'(bus.dvalid), 16'd1);
        check_pulses("sparse", 1'b0, 1'b0, 1'b0);
        drain();

        // Parity error, then a good frame.
        frame(4'b1011, 1'b0, 1'b1, 0, 1'b0);
        check_pulses("par", 1'b1, 1'b0, 1'b0);
        check("par_dvalid", 16'(bus.dvalid), 16'd0);
        check("par_busy", 16'(bus.busy), 16'd0);
        @(posedge clk);
        #1;
        check("par_pulse_end", 16'(bus.perr), 16'd0);
        frame(4'b0011, 1'b0, 1'b1, 0, 1'b0);
        check("par2_dout", 16'(bus.dout), 16'h3);
        check("par2_dvalid", 16'(bus.dvalid), 16'd1);
        drain();

        // Framing error with bad parity too, then back-to-back good frame.
        frame(4'b1111, 1'b1, 1'b0, 0, 1'b0);
        check_pulses("ferr", 1'b0, 1'b1, 1'b0);
        check("ferr_dvalid", 16'(bus.dvalid), 16'd0);
        frame(4'b0100, 1'b1, 1'b1, 0, 1'b0);
        check("b2b_dout", 16'(bus.dout), 16'h4);
        check("b2b_dvalid", 16'(bus.dvalid), 16'd1);
        check_pulses("b2b", 1'b0, 1'b0, 1'b0);
        drain();

        // Overrun, then commit on the same edge as a drain.
        frame(4'b1011, 1'b1, 1'b1, 0, 1'b0);
        check("ovr1_dout", 16'(bus.dout), 16'hb);
        frame(4'b0011, 1'b0, 1'b1, 0, 1'b0);
        check_pulses("ovr2", 1'b0, 1'b0, 1'b1);
        check("ovr2_dout", 16'(bus.dout), 16'hb);
        check("ovr2_dvalid", 16'(bus.dvalid), 16'd1);
        frame(4'b0100, 1'b1, 1'b1, 0, 1'b1);
        check("swap_dout", 16'(bus.dout), 16'h4);
        check("swap_dvalid", 16'(bus.dvalid), 16'd1);
        check_pulses("swap", 1'b0, 1'b0, 1'b0);

        // Reset mid-frame discards both the frame and the buffered word.
        send_bit(1'b0, 0, 1'b0);
        send_bit(1'b1, 0, 1'b0);
        send_bit(1'b0, 0, 1'b0);
        check("pre_rst_busy", 16'(bus.busy), 16'd1);
        check("pre_rst_dvalid", 16'(bus.dvalid), 16'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_dout", 16'(bus.dout), 16'h0);
        check("mid_rst_dvalid", 16'(bus.dvalid), 16'd0);
        check("mid_rst_busy", 16'(bus.busy), 16'd0);
        check_pulses("mid_rst", 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        frame(4'b1010, 1'b0, 1'b1, 0, 1'b0);
        check("post_rst_dout", 16'(bus.dout), 16'ha);
        check("post_rst_dvalid", 16'(bus.dvalid), 16'd1);
        check_pulses("post_rst", 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ser_word_rx.md
# ser_word_rx

Serial-to-parallel frame receiver that sits directly downstream of the universal shift register in the serial path. It consumes the bit stream the shift register emits, one bit per strobe. It recognises a start/data/parity/stop frame and assembles the data bits into a parallel word. Completed words are offered on a one-entry valid/ready output buffer, with single-cycle error pulses for framing, parity and overrun faults.

## Interface
- WIDTH, 4: data bits per frame (2..16).
- clk  input  1  sole clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- sdi  input  1  serial data bit.
- sen  input  1  bit strobe; sdi is sampled only in cycles where sen=1.
- dout  output  WIDTH  received word, held stable while dvalid=1.
- dvalid  output  1  dout holds an unconsumed word.
- dready  input  1  consumer accepts dout in any cycle with dvalid=1 and dready=1.
- busy  output  1  1 whenever the FSM is not in IDLE.
- perr  output  1  one-cycle pulse when the parity check fails.
- ferr  output  1  one-cycle pulse when the stop bit is 0.
- ovr  output  1  one-cycle pulse when a good word is dropped because the buffer is full.

## Operation
- Frame format, in order of arrival: start bit (0), then WIDTH data bits MSB first, then an even-parity bit, then a stop bit (1). The line idles at 1.
- Even parity: XOR of the data bits and the parity bit must equal 0.
- All FSM activity advances only on cycles with sen=1. Cycles with sen=0 hold all state, including the bit counter.
- FSM states are IDLE, DATA, PARITY and STOP.
- IDLE: sen=1 with sdi=0 moves to DATA and clears the bit counter. sen=1 with sdi=1 stays in IDLE.
- DATA: on each sen, shift the bit in with shreg <= {shreg[WIDTH-2:0], sdi} and increment the counter. When the counter reaches WIDTH-1 on a strobe, that bit is shifted in and the FSM moves to PARITY.
- PARITY: on sen, latch par_bad = (^shreg) ^ sdi and move to STOP.
- STOP, on sen, the FSM always returns to IDLE and resolves in this priority order:
  - sdi=0: pulse ferr and discard the word. No perr is raised even if par_bad=1.
  - sdi=1 and par_bad=1: pulse perr and discard the word.
  - sdi=1 and par_bad=0 with the buffer free: commit the word. The buffer is free when dvalid=0, or when dvalid=1 and dready=1 in that same cycle.
  - sdi=1 and par_bad=0 with the buffer not free: pulse ovr and drop the new word. The old dout and dvalid are unchanged.
- Commit: dout <= shreg and dvalid <= 1.
- Handshake: dvalid falls on the clock edge after a cycle with dvalid=1 and dready=1, unless a commit happens on that same edge. In that case dvalid stays 1 and dout takes the new word.
- dready is ignored while dvalid=0.
- A start bit can be detected in the cycle immediately after a stop-bit strobe. Back-to-back frames need no idle bits.

## Timing
- Reset values: dout=0, dvalid=0, busy=0, perr=0, ferr=0, ovr=0. Internally, the FSM is in IDLE and shreg, the counter and par_bad are 0.
- Asserting rst mid-frame aborts the frame immediately. Any buffered word is lost, and no error pulse is generated.
- Outputs are registered, with no combinational path from any input to any output.
- busy rises on the edge that accepts the start bit and falls on the edge that processes the stop bit.
- Latency: dvalid, perr, ferr and ovr all assert on the edge of the stop-bit strobe cycle, so they are visible the cycle after that strobe.
- Minimum frame length is WIDTH+3 strobes, so at most one word completes per WIDTH+3 sen cycles.

## Test plan
- Good frame, WIDTH=4, sen=1 every cycle. Drive sdi sequence 0, 1,0,1,1, 1, 1. Expect dout=4'b1011 and dvalid=1 one cycle after the stop strobe, with no error pulses. Assert dready for one cycle and expect dvalid=0 next cycle.
- Sparse strobes. Repeat the good frame with sen=1 only every third cycle and random sdi on sen=0 cycles. Expect the same dout=1011 and busy held high throughout.
- Parity error. Drive 0, 1,0,1,1, 0, 1. Expect a single perr pulse, dvalid stays 0, FSM back in IDLE. Then drive frame 0, 0,0,1,1, 0, 1 and expect dout=4'b0011.
- Framing error and back-to-back. Drive 0, 1,1,1,1, 0, 0. Expect a ferr pulse and no perr. Immediately follow with frame 0, 0,1,0,0, 1, 1 and expect dout=4'b0100.
- Overrun and simultaneous drain.
  - With dready=0, send 1011 and then 0011. Expect dout to stay 1011 and an ovr pulse on the second stop.
  - Next, send 0100 with dready=1 during its stop-strobe cycle. Expect dvalid to remain 1, dout=0100 and no ovr.
- Reset mid-frame. Assert rst after two data bits. Expect all outputs 0 and busy=0. A following good frame 1010 must produce dout=4'b1010.
